// File: rtl/mat_pkg.sv
// Shared definitions for the matrix result serializer: default geometry,
// FSM state encoding, traversal order encoding and element offset helper.
package mat_pkg;

  localparam int MAT_DIM    = 4;
  localparam int MAT_ELEM_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic ROW_MAJOR = 1'b0;
  localparam logic COL_MAJOR = 1'b1;

  // Bit offset of element (r,c) inside the flattened matrix bus.
  function automatic int elem_idx(input int r, input int c,
                                  input int dim = MAT_DIM,
                                  input int elem_w = MAT_ELEM_W);
    return (r * dim + c) * elem_w;
  endfunction

endpackage

// File: rtl/matrix_result_serializer_if.sv
// Capture side (wide matrix in) and stream side (one element per beat out)
// of the serializer. The serializer uses the slave view; the environment
// that supplies matrices and consumes beats uses the master view.
interface matrix_result_serializer_if
  import mat_pkg::*;
#(
  parameter int DIM    = MAT_DIM,
  parameter int ELEM_W = MAT_ELEM_W,
  parameter int IDX_W  = $clog2(MAT_DIM)
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [DIM*DIM*ELEM_W-1:0] in_matrix;
  logic                      in_order;
  logic                      out_valid;
  logic                      out_ready;
  logic [ELEM_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_row;
  logic [IDX_W-1:0]          out_col;
  logic                      out_last;
  logic                      busy;

  modport slave (
    input  in_valid, in_matrix, in_order, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last, busy
  );

  modport master (
    output in_valid, in_matrix, in_order, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last, busy
  );

endinterface

// File: rtl/mat_elem_mux.sv
// Selects one element of the held matrix by row/column index.
module mat_elem_mux
  import mat_pkg::*;
#(
  parameter int DIM    = MAT_DIM,
  parameter int ELEM_W = MAT_ELEM_W,
  parameter int IDX_W  = $clog2(MAT_DIM)
) (
  input  logic [DIM*DIM*ELEM_W-1:0] matrix_i,
  input  logic [IDX_W-1:0]          row_i,
  input  logic [IDX_W-1:0]          col_i,
  output logic [ELEM_W-1:0]         elem_o
);

  // Pure part-select; values pass through untouched.
  always_comb begin
    elem_o = matrix_i[elem_idx(int'(row_i), int'(col_i), DIM, ELEM_W) +: ELEM_W];
  end

endmodule

// File: rtl/matrix_result_serializer.sv
// Holds one DIM x DIM product matrix and streams it out one element per
// accepted beat, row- or column-major, with row/col tags and a last flag.
// The last-beat transfer can capture the next matrix in the same cycle so
// consecutive matrices stream with no bubble.
module matrix_result_serializer
  import mat_pkg::*;
#(
  parameter int DIM    = MAT_DIM,
  parameter int ELEM_W = MAT_ELEM_W,
  parameter int IDX_W  = $clog2(MAT_DIM)
) (
  input logic                    clk,
  input logic                    reset,
  matrix_result_serializer_if.slave bus
);

  localparam int                 CNT_W  = $clog2(DIM * DIM);
  localparam logic [CNT_W-1:0]   LAST_K = CNT_W'(DIM * DIM - 1);
  localparam logic [CNT_W-1:0]   K_ONE  = CNT_W'(1);

  state_t                    state_q;
  logic [CNT_W-1:0]          k_q;
  logic                      order_q;
  logic [DIM*DIM*ELEM_W-1:0] buf_q;

  logic [IDX_W-1:0]          row;
  logic [IDX_W-1:0]          col;
  logic [ELEM_W-1:0]         elem;
  logic                      last;
  logic                      xfer;
  logic                      accept;

  // Beat index to (row,col) for the order captured with the matrix.
  always_comb begin
    row = IDX_W'(int'(k_q) / DIM);
    col = IDX_W'(int'(k_q) % DIM);
    if (order_q == COL_MAJOR) begin
      row = IDX_W'(int'(k_q) % DIM);
      col = IDX_W'(int'(k_q) / DIM);
    end
  end

  mat_elem_mux #(
    .DIM    (DIM),
    .ELEM_W (ELEM_W),
    .IDX_W  (IDX_W)
  ) u_elem_mux (
    .matrix_i (buf_q),
    .row_i    (row),
    .col_i    (col),
    .elem_o   (elem)
  );

  assign last   = (k_q == LAST_K);
  assign xfer   = (state_q == SEND) && bus.out_ready;
  // in_ready is gated by reset so nothing appears accepted during reset.
  assign accept = reset && ((state_q == IDLE) || (xfer && last));

  assign bus.in_ready  = accept;
  assign bus.out_valid = (state_q == SEND);
  assign bus.busy      = (state_q == SEND);
  assign bus.out_data  = (state_q == SEND) ? elem : '0;
  assign bus.out_row   = row;
  assign bus.out_col   = col;
  assign bus.out_last  = (state_q == SEND) && last;

  // Capture / drain FSM with beat counter; the counter returns to 0 on exit
  // so idle row/col tags read 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      order_q <= ROW_MAJOR;
      buf_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            buf_q   <= bus.in_matrix;
            order_q <= bus.in_order;
            k_q     <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last) begin
              k_q <= '0;
              if (bus.in_valid) begin
                buf_q   <= bus.in_matrix;
                order_q <= bus.in_order;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              k_q <= k_q + K_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: reset, row/column-major
// drains, backpressure, back-to-back matrices and mid-drain reset.
module tb_matrix_result_serializer;
  import mat_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  matrix_result_serializer_if bus_if ();

  matrix_result_serializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // kind 0: element (r,c) = r*4+c+1; kind 1: every element 0xA5A5A5A5.
  function automatic logic [511:0] make_mat(input int kind);
    logic [511:0] m;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[(r*4+c)*32 +: 32] = (kind == 1) ? 32'hA5A5A5A5 : 32'(r*4 + c + 1);
    return m;
  endfunction

  function automatic logic [31:0] exp_data(input int kind, input int r, input int c);
    return (kind == 1) ? 32'hA5A5A5A5 : 32'(r*4 + c + 1);
  endfunction

  // Called just after a negedge; presents a matrix for one capture edge.
  task automatic start_matrix(input int kind, input logic ord);
    bus_if.in_valid  = 1'b1;
    bus_if.in_matrix = make_mat(kind);
    bus_if.in_order  = ord;
    bus_if.out_ready = 1'b1;
    #1;
    chk("cap_in_ready", bus_if.in_ready, 1);
    chk("cap_out_valid", bus_if.out_valid, 0);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  // Drains up to max_beats beats, checking every cycle against the model.
  // Returns just after a negedge.
  task automatic drain(input int kind, input logic ord, input int pct,
                       input int max_beats, input string tag);
    int  eb;
    int  r;
    int  c;
    bit  done;
    eb   = 0;
    done = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (eb == max_beats) begin
        done = 1;
      end else begin
        bus_if.out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99, 0) < pct);
        #1;
        r = ord ? (eb % 4) : (eb / 4);
        c = ord ? (eb / 4) : (eb % 4);
        chk({tag, "_valid"}, bus_if.out_valid, 1);
        chk({tag, "_busy"},  bus_if.busy, 1);
        chk({tag, "_data"},  bus_if.out_data, exp_data(kind, r, c));
        chk({tag, "_row"},   bus_if.out_row, r);
        chk({tag, "_col"},   bus_if.out_col, c);
        chk({tag, "_last"},  bus_if.out_last, (eb == 15));
        chk({tag, "_in_ready"}, bus_if.in_ready, bus_if.out_ready && (eb == 15));
        if (bus_if.out_ready) eb++;
        if (eb == 16) done = 1;
        @(negedge clk);
      end
    end
    chk({tag, "_beats"}, eb, max_beats);
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_valid"},    bus_if.out_valid, 0);
    chk({tag, "_busy"},     bus_if.busy, 0);
    chk({tag, "_in_ready"}, bus_if.in_ready, 1);
    chk({tag, "_last"},     bus_if.out_last, 0);
    chk({tag, "_data"},     bus_if.out_data, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_matrix = '0;
    bus_if.in_order  = 1'b0;
    bus_if.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",  bus_if.in_ready, 0);
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_busy",      bus_if.busy, 0);
    chk("rst_data",      bus_if.out_data, 0);
    chk("rst_row",       bus_if.out_row, 0);
    chk("rst_col",       bus_if.out_col, 0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) chk_idle("idle");

    start_matrix(0, ROW_MAJOR);
    drain(0, ROW_MAJOR, 100, 16, "row");
    chk_idle("row_end");

    start_matrix(0, COL_MAJOR);
    drain(0, COL_MAJOR, 100, 16, "col");
    chk_idle("col_end");

    start_matrix(0, ROW_MAJOR);
    drain(0, ROW_MAJOR, 50, 16, "bp_row");
    chk_idle("bp_row_end");

    start_matrix(0, COL_MAJOR);
    drain(0, COL_MAJOR, 50, 16, "bp_col");
    chk_idle("bp_col_end");

    start_matrix(0, ROW_MAJOR);
    bus_if.in_valid  = 1'b1;
    bus_if.in_matrix = make_mat(1);
    bus_if.in_order  = ROW_MAJOR;
    drain(0, ROW_MAJOR, 70, 16, "b2b_a");
    bus_if.in_valid = 1'b0;
    drain(1, ROW_MAJOR, 100, 16, "b2b_b");
    chk_idle("b2b_end");

    start_matrix(0, ROW_MAJOR);
    drain(0, ROW_MAJOR, 100, 7, "pre_abort");
    reset = 1'b0;
    #1;
    chk("abort_valid",    bus_if.out_valid, 0);
    chk("abort_busy",     bus_if.busy, 0);
    chk("abort_in_ready", bus_if.in_ready, 0);
    chk("abort_data",     bus_if.out_data, 0);
    chk("abort_row",      bus_if.out_row, 0);
    chk("abort_col",      bus_if.out_col, 0);
    @(negedge clk);
    reset = 1'b1;
    chk_idle("post_abort");
    start_matrix(0, COL_MAJOR);
    drain(0, COL_MAJOR, 100, 16, "restart");
    chk_idle("restart_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
